if_stage: RTL and testbench

Instruction fetch stage of the out-of-order core. Generates the fetch PC, drives a one-cycle-latency instruction memory, and buffers returned instructions in a small fetch queue. The queue presents `{pc, inst, jump}` to the decode/dispatch stage through a valid/ready handshake. It predicts JAL as taken in fetch and flushes cleanly on a back-end mispredict.

---
 rtl/if_stage_if.sv | 26 ++
 rtl/if_stage.sv | 107 ++++++++++
 tb/tb_if_stage.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage port bundle: instruction-memory request/response plus decode handshake.
// Latency: n/a (wires only).
// Backpressure: DC_ready stalls the fetch-queue head; mispredict flushes.
//   master: the fetch stage   slave: memory + decode + back end
interface if_stage_if;
  logic        im_en;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        IF_valid;
  logic [31:0] IF_out_pc;
  logic [31:0] IF_out_inst;
  logic        IF_out_jump;
  logic        DC_ready;
  logic        mispredict;
  logic [31:0] redirect_pc;

  modport master (
    output im_en, im_addr, IF_valid, IF_out_pc, IF_out_inst, IF_out_jump,
    input  im_rdata, DC_ready, mispredict, redirect_pc
  );

  modport slave (
    input  im_en, im_addr, IF_valid, IF_out_pc, IF_out_inst, IF_out_jump,
    output im_rdata, DC_ready, mispredict, redirect_pc
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC generation, 1-cycle imem access, FQ_DEPTH-entry fetch queue, JAL predicted taken.
// Latency: request at t, enqueue end of t+1, IF_valid at t+2; mispredict gives first redirected entry at t+3.
// Backpressure: DC_ready low holds the head; no request issues once queue + in-flight response fills the queue.
//   Ports: clk, rst (sync, active-high); bus (if_stage_if.master) carrying im_en/im_addr/im_rdata,
//   IF_valid/IF_out_pc/IF_out_inst/IF_out_jump, DC_ready, mispredict/redirect_pc.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.master  bus
);
  localparam int AW = $clog2(FQ_DEPTH);

  logic [31:0]         pc;
  logic [31:0]         q_pc   [FQ_DEPTH];
  logic [31:0]         q_inst [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] q_jump;
  logic [AW-1:0]       head, tail;
  logic [AW:0]         count;

  // Tracker for the request issued in the previous cycle.
  logic        rsp_v;
  logic        rsp_kill;
  logic [31:0] rsp_pc;

  logic        rsp_live;
  logic        push;
  logic        pop;
  logic        is_jal;
  logic        issue;
  logic [AW+1:0] occupancy;
  logic [31:0] j_imm;

  assign rsp_live  = rsp_v && !rsp_kill;
  assign push      = rsp_live && !bus.mispredict;
  assign is_jal    = push && (bus.im_rdata[6:0] == 7'b1101111);
  assign pop       = (count != '0) && bus.DC_ready;

  // Reserve a slot for the response still in flight so the queue can never overflow.
  assign occupancy = {1'b0, count} + {{(AW+1){1'b0}}, rsp_live};
  assign issue     = !rst && !bus.mispredict && (occupancy < (AW+2)'(FQ_DEPTH));

  assign j_imm = {{11{bus.im_rdata[31]}}, bus.im_rdata[31], bus.im_rdata[19:12],
                  bus.im_rdata[20], bus.im_rdata[30:21], 1'b0};

  assign bus.im_en       = issue;
  assign bus.im_addr     = pc;
  assign bus.IF_valid    = (count != '0);
  assign bus.IF_out_pc   = q_pc[head];
  assign bus.IF_out_inst = q_inst[head];
  assign bus.IF_out_jump = q_jump[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      rsp_v    <= 1'b0;
      rsp_kill <= 1'b0;
      rsp_pc   <= '0;
      q_jump   <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_inst[i] <= '0;
      end
    end else begin
      // issue is already low under mispredict, so the tracker empties itself.
      rsp_v    <= issue;
      rsp_pc   <= pc;
      // The sequential request issued alongside a JAL response is wrong-path.
      rsp_kill <= is_jal;

      if (bus.mispredict) begin
        pc    <= bus.redirect_pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (is_jal) begin
          pc <= rsp_pc + j_imm;
        end else if (issue) begin
          pc <= pc + 32'd4;
        end

        if (push) begin
          q_pc[tail]   <= rsp_pc;
          q_inst[tail] <= bus.im_rdata;
          q_jump[tail] <= is_jal;
          tail         <= tail + AW'(1);
        end

        if (pop) begin
          head <= head + AW'(1);
        end

        unique case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;

  if_stage_if bus();

  if_stage #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: 64 words, aliased by address bits [7:2].
  // mem_jal/mem_off describe each word's control-flow meaning directly.
  logic [31:0] mem_word [64];
  bit          mem_jal  [64];
  int          mem_off  [64];

  function automatic int idx(logic [31:0] a);
    return int'(a[7:2]);
  endfunction

  function automatic logic [31:0] jal_enc(int off);
    logic [20:0] imm;
    imm = off[20:0];
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  task automatic set_nop(int i);
    mem_word[i] = NOP; mem_jal[i] = 1'b0; mem_off[i] = 0;
  endtask

  task automatic set_jal(int i, int off);
    mem_word[i] = jal_enc(off); mem_jal[i] = 1'b1; mem_off[i] = off;
  endtask

  // Reference model: fetch queue and in-flight request as plain queue/variables.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          jump;
  } ent_t;

  ent_t        fq[$];
  logic [31:0] mpc;
  bit          m_rv, m_rk;
  logic [31:0] m_rpc;
  bit          known = 1'b0;
  logic [31:0] prev_addr = '0;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Per-cycle samples for the directed literal expectations.
  logic        s_en    [256];
  logic        s_valid [256];
  logic        s_jump  [256];
  logic [31:0] s_addr  [256];
  logic [31:0] s_pc    [256];
  logic [31:0] s_inst  [256];

  logic [31:0] pop_pc[$];
  bit          pop_jump[$];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
  endtask

  // One clock cycle: drive inputs after the negedge, compare, advance the model.
  task automatic step(bit r, bit rdy, bit mp, logic [31:0] rp);
    bit   live, exp_en, jal;
    ent_t e;
    bus.im_rdata    = mem_word[idx(prev_addr)];
    rst             = r;
    bus.DC_ready    = rdy;
    bus.mispredict  = mp;
    bus.redirect_pc = rp;
    #1;
    live   = m_rv && !m_rk;
    exp_en = !r && !mp && ((fq.size() + int'(live)) < DEPTH);
    if (known) begin
      chk("im_en", 32'(bus.im_en), 32'(exp_en));
      chk("im_addr", bus.im_addr, mpc);
      chk("IF_valid", 32'(bus.IF_valid), 32'(fq.size() != 0));
      if (fq.size() != 0) begin
        chk("IF_out_pc", bus.IF_out_pc, fq[0].pc);
        chk("IF_out_inst", bus.IF_out_inst, fq[0].inst);
        chk("IF_out_jump", 32'(bus.IF_out_jump), 32'(fq[0].jump));
      end
    end
    if (cyc < 256) begin
      s_en[cyc]    = bus.im_en;
      s_valid[cyc] = bus.IF_valid;
      s_jump[cyc]  = bus.IF_out_jump;
      s_addr[cyc]  = bus.im_addr;
      s_pc[cyc]    = bus.IF_out_pc;
      s_inst[cyc]  = bus.IF_out_inst;
    end
    if (!r && !mp && bus.IF_valid && rdy) begin
      pop_pc.push_back(bus.IF_out_pc);
      pop_jump.push_back(bus.IF_out_jump);
    end
    prev_addr = bus.im_addr;

    if (r) begin
      fq.delete(); mpc = RPC; m_rv = 1'b0; m_rk = 1'b0; m_rpc = '0; known = 1'b1;
    end else if (mp) begin
      fq.delete(); mpc = rp; m_rv = 1'b0; m_rk = 1'b0;
    end else begin
      jal = 1'b0;
      if (fq.size() != 0 && rdy) void'(fq.pop_front());
      if (live) begin
        e.pc   = m_rpc;
        e.inst = mem_word[idx(m_rpc)];
        e.jump = mem_jal[idx(m_rpc)];
        jal    = e.jump;
        fq.push_back(e);
      end
      m_rk  = jal;
      m_rv  = exp_en;
      m_rpc = mpc;
      if (jal) mpc = e.pc + 32'(mem_off[idx(e.pc)]);
      else if (exp_en) mpc = mpc + 32'd4;
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int t, p, m, u, v, w, mode, thr;
    logic [31:0] exp_a [7];
    logic [31:0] rp, wv;
    bit r, mp, rdy;

    bus.im_rdata = '0; bus.DC_ready = 1'b0; bus.mispredict = 1'b0; bus.redirect_pc = '0;
    for (int i = 0; i < 64; i++) set_nop(i);
    set_jal(4, 32'h40);      // JAL at 0x10, target 0x50
    @(negedge clk);

    // Reset and reset values.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("rst_im_en", 32'(s_en[1]), 0);
    chk("rst_im_addr", s_addr[1], RPC);
    chk("rst_valid", 32'(s_valid[1]), 0);
    chk("rst_pc", s_pc[1], 0);
    chk("rst_inst", s_inst[1], 0);
    chk("rst_jump", 32'(s_jump[1]), 0);

    // Streaming NOPs with a JAL at 0x10.
    pop_pc.delete(); pop_jump.delete();
    t = cyc;
    repeat (12) step(0, 1, 0, 0);
    chk("first_req_en", 32'(s_en[t]), 1);
    chk("first_req_addr", s_addr[t], 32'h0);
    chk("second_req_addr", s_addr[t+1], 32'h4);
    chk("valid_t1", 32'(s_valid[t+1]), 0);
    chk("valid_t2", 32'(s_valid[t+2]), 1);
    exp_a = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h50, 32'h54};
    chk("stream_popcnt", 32'(pop_pc.size() >= 7), 1);
    for (int i = 0; i < 7; i++) begin
      chk("stream_pc", (i < pop_pc.size()) ? pop_pc[i] : 32'hDEAD_BEEF, exp_a[i]);
      chk("stream_jump", (i < pop_jump.size()) ? 32'(pop_jump[i]) : 32'hDEAD_BEEF, 32'(i == 4));
    end

    // Backpressure: fill the queue from 0x100, then flush with a response in flight.
    t = cyc;
    step(0, 0, 1, 32'h100);
    repeat (8) step(0, 0, 0, 0);
    chk("full_valid", 32'(s_valid[t+8]), 1);
    chk("full_no_req", 32'(s_en[t+8]), 0);
    chk("full_head_pc", s_pc[t+8], 32'h100);
    p = cyc;
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    m = cyc;
    step(0, 0, 1, 32'h200);
    repeat (4) step(0, 1, 0, 0);
    chk("pop_cycle_no_req", 32'(s_en[p]), 0);
    chk("req_after_pop", 32'(s_en[p+1]), 1);
    chk("req_after_pop_addr", s_addr[p+1], 32'h110);
    chk("flush_valid_t1", 32'(s_valid[m+1]), 0);
    chk("flush_req_t1", 32'(s_en[m+1]), 1);
    chk("flush_addr_t1", s_addr[m+1], 32'h200);
    chk("flush_valid_t2", 32'(s_valid[m+2]), 0);
    chk("flush_valid_t3", 32'(s_valid[m+3]), 1);
    chk("flush_pc_t3", s_pc[m+3], 32'h200);

    // Mispredict in the same cycle the JAL at 0x10 returns.
    u = cyc;
    step(0, 1, 1, 32'h8);
    repeat (3) step(0, 1, 0, 0);
    v = cyc;
    step(0, 1, 1, 32'h400);
    repeat (4) step(0, 1, 0, 0);
    chk("jal_req_addr", s_addr[u+3], 32'h10);
    chk("jalflush_valid_t1", 32'(s_valid[v+1]), 0);
    chk("jalflush_valid_t2", 32'(s_valid[v+2]), 0);
    chk("jalflush_addr_t1", s_addr[v+1], 32'h400);
    chk("jalflush_valid_t3", 32'(s_valid[v+3]), 1);
    chk("jalflush_pc_t3", s_pc[v+3], 32'h400);

    // Address wrap through 2^32.
    w = cyc;
    step(0, 1, 1, 32'hFFFF_FFF8);
    repeat (6) step(0, 1, 0, 0);
    chk("wrap_addr1", s_addr[w+1], 32'hFFFF_FFF8);
    chk("wrap_addr2", s_addr[w+2], 32'hFFFF_FFFC);
    chk("wrap_addr3", s_addr[w+3], 32'h0000_0000);
    chk("wrap_pc1", s_pc[w+3], 32'hFFFF_FFF8);
    chk("wrap_pc2", s_pc[w+4], 32'hFFFF_FFFC);
    chk("wrap_pc3", s_pc[w+5], 32'h0000_0000);

    // Randomised program and traffic against the model.
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        set_jal(i, int'($urandom_range(0, 128)) * 4 - 256);
      end else begin
        wv = $urandom;
        if (wv[6:0] == 7'b1101111) wv[6:0] = 7'b0010011;
        mem_word[i] = wv; mem_jal[i] = 1'b0; mem_off[i] = 0;
      end
    end
    for (int i = 0; i < 3000; i++) begin
      mode = (i / 64) % 3;
      thr  = (mode == 0) ? 9 : ((mode == 1) ? 5 : 1);
      rdy  = ($urandom_range(0, 9) < thr);
      r    = ($urandom_range(0, 199) == 0);
      mp   = ($urandom_range(0, 29) == 0);
      rp   = $urandom;
      rp[1:0] = 2'b00;
      step(r, rdy, mp, rp);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
